// File: rtl/spi_word_router_if.sv
// Bus bundle between the SPI word receiver (master side) and the word router (slave side).
// The slave drives the routed channel outputs and the drop counter.
`timescale 1ns/1ps
interface spi_word_router_if #(
   parameter int CHANNEL_COUNT     = 4,
   parameter int ADDRESS_BUS_WIDTH = 13,
   parameter int DATA_WIDTH        = 16
);
   logic [DATA_WIDTH-1:0]                          spi_data;
   logic [ADDRESS_BUS_WIDTH:0]                     spi_word_address;
   logic                                           spi_write_strobe;
   logic [DATA_WIDTH-1:0]                          ch_data;
   logic [CHANNEL_COUNT*(ADDRESS_BUS_WIDTH+1)-1:0] ch_address;
   logic [CHANNEL_COUNT-1:0]                       ch_write_strobe;
   logic [CHANNEL_COUNT-1:0]                       ch_last_word;
   logic                                           frame_commit;
   logic                                           out_of_range;
   logic [15:0]                                    drop_count;

   modport master (
      output spi_data, spi_word_address, spi_write_strobe,
      input  ch_data, ch_address, ch_write_strobe, ch_last_word,
             frame_commit, out_of_range, drop_count
   );

   modport slave (
      input  spi_data, spi_word_address, spi_write_strobe,
      output ch_data, ch_address, ch_write_strobe, ch_last_word,
             frame_commit, out_of_range, drop_count
   );
endinterface

// File: rtl/spi_word_router.sv
// Routes flat SPI word writes to per-channel regions, flags last words and commits complete frames.
// Optional drop statistics counter enabled by defining SPI_WORD_ROUTER_STATS_EN.
`timescale 1ns/1ps
module spi_word_router #(
   parameter int CHANNEL_COUNT     = 4,
   parameter int ADDRESS_BUS_WIDTH = 13,
   parameter int DATA_WIDTH        = 16,
   parameter logic [CHANNEL_COUNT*(ADDRESS_BUS_WIDTH+1)-1:0] CHANNEL_WORDS =
      {14'd96, 14'd1344, 14'd2688, 14'd2688}
) (
   input  logic             clk,
   input  logic             rst_n,
   spi_word_router_if.slave bus
);
   localparam int AW = ADDRESS_BUS_WIDTH + 1;
   localparam int SW = AW + 2;

   function automatic logic [SW-1:0] wordsOf(int idx);
      return {2'b00, CHANNEL_WORDS[idx*AW +: AW]};
   endfunction

   function automatic logic [SW-1:0] offsetOf(int idx);
      logic [SW-1:0] sum;
      sum = '0;
      for (int k = 0; k < idx; k++) sum = sum + wordsOf(k);
      return sum;
   endfunction

   function automatic longint totalWords();
      longint total;
      total = 0;
      for (int k = 0; k < CHANNEL_COUNT; k++) total = total + longint'(CHANNEL_WORDS[k*AW +: AW]);
      return total;
   endfunction

   function automatic logic [CHANNEL_COUNT-1:0] populatedMask();
      logic [CHANNEL_COUNT-1:0] m;
      m = '0;
      for (int k = 0; k < CHANNEL_COUNT; k++) m[k] = (CHANNEL_WORDS[k*AW +: AW] != '0);
      return m;
   endfunction

   localparam logic [CHANNEL_COUNT-1:0] POPULATED = populatedMask();

   if (CHANNEL_COUNT < 1 || CHANNEL_COUNT > 16) begin : gBadCount
      $error("spi_word_router: CHANNEL_COUNT must be within 1..16");
   end
   if (totalWords() > (longint'(1) << AW)) begin : gBadTotal
      $error("spi_word_router: CHANNEL_WORDS total exceeds the address space");
   end

   logic [SW-1:0]               addrExt;
   logic [CHANNEL_COUNT-1:0]    hit;
   logic [CHANNEL_COUNT-1:0]    isLast;
   logic [CHANNEL_COUNT*AW-1:0] localAddr;

   assign addrExt = {2'b00, bus.spi_word_address};

   // Each channel decodes its own region in parallel; an empty region never hits.
   for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : gChan
      localparam logic [SW-1:0] OFF   = offsetOf(g);
      localparam logic [SW-1:0] WORDS = wordsOf(g);
      logic [SW-1:0] diff;
      assign diff                  = addrExt - OFF;
      assign hit[g]                = (WORDS != '0) && (addrExt >= OFF) && (diff < WORDS);
      assign isLast[g]             = (diff == WORDS - 1'b1);
      assign localAddr[g*AW +: AW] = diff[AW-1:0];
   end

   logic [DATA_WIDTH-1:0]       chData_q, chData_d;
   logic [CHANNEL_COUNT*AW-1:0] chAddress_q, chAddress_d;
   logic [CHANNEL_COUNT-1:0]    chStrobe_q, chStrobe_d;
   logic [CHANNEL_COUNT-1:0]    chLast_q, chLast_d;
   logic [CHANNEL_COUNT-1:0]    mask_q, mask_d;
   logic                        commit_q, commit_d;
   logic                        outOfRange_q, outOfRange_d;
   logic [CHANNEL_COUNT-1:0]    newMask;

   always_comb begin
      chData_d     = chData_q;
      chAddress_d  = chAddress_q;
      chStrobe_d   = '0;
      chLast_d     = '0;
      mask_d       = mask_q;
      commit_d     = 1'b0;
      outOfRange_d = 1'b0;
      newMask      = mask_q;
      if (bus.spi_write_strobe) begin
         if (|hit) begin
            chStrobe_d = hit;
            chLast_d   = hit & isLast;
            chData_d   = bus.spi_data;
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
               if (hit[i]) chAddress_d[i*AW +: AW] = localAddr[i*AW +: AW];
            end
            // The completing write commits and leaves nothing behind in the mask.
            if (|chLast_d) begin
               newMask = mask_q | chLast_d;
               if ((newMask & POPULATED) == POPULATED) begin
                  commit_d = 1'b1;
                  mask_d   = '0;
               end else begin
                  mask_d = newMask;
               end
            end
         end else begin
            outOfRange_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chData_q     <= '0;
         chAddress_q  <= '0;
         chStrobe_q   <= '0;
         chLast_q     <= '0;
         mask_q       <= '0;
         commit_q     <= 1'b0;
         outOfRange_q <= 1'b0;
      end else begin
         chData_q     <= chData_d;
         chAddress_q  <= chAddress_d;
         chStrobe_q   <= chStrobe_d;
         chLast_q     <= chLast_d;
         mask_q       <= mask_d;
         commit_q     <= commit_d;
         outOfRange_q <= outOfRange_d;
      end
   end

   assign bus.ch_data         = chData_q;
   assign bus.ch_address      = chAddress_q;
   assign bus.ch_write_strobe = chStrobe_q;
   assign bus.ch_last_word    = chLast_q;
   assign bus.frame_commit    = commit_q;
   assign bus.out_of_range    = outOfRange_q;

`ifdef SPI_WORD_ROUTER_STATS_EN
   logic [15:0] dropCount_q, dropCount_d;

   // Counts alongside the registered pulse so both become visible in the same cycle.
   always_comb begin
      dropCount_d = dropCount_q;
      if (outOfRange_d && dropCount_q != 16'hFFFF) dropCount_d = dropCount_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dropCount_q <= '0;
      else        dropCount_q <= dropCount_d;
   end

   assign bus.drop_count = dropCount_q;
`else
   assign bus.drop_count = 16'd0;
`endif
endmodule

// File: tb/tb_spi_word_router.sv
// Randomised scoreboard bench for spi_word_router: default layout plus a single-populated-channel layout.
// Expected responses come from a region-search reference model; a monitor per instance pops and compares.
`timescale 1ns/1ps
module tb_spi_word_router;
   localparam int AW = 14;
   localparam logic [4*AW-1:0] WORDS_B = {14'd10, 14'd0, 14'd0, 14'd0};

   typedef struct {
      int          cycle;
      logic [3:0]  strobe;
      logic [3:0]  last;
      logic        commit;
      logic        oor;
      logic [15:0] data;
      logic [55:0] addr;
      logic [15:0] drops;
   } evT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cycle = 0;
   int   checks = 0;
   int   errors = 0;

   evT expA[$];
   evT expB[$];
   evT curA, curB;

   int          words[2][4];
   logic [3:0]  mSeen[2];
   logic [15:0] mData[2];
   logic [55:0] mAddr[2];
   int          mDrops[2];

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   spi_word_router_if #(.CHANNEL_COUNT(4), .ADDRESS_BUS_WIDTH(13), .DATA_WIDTH(16)) busA();
   spi_word_router_if #(.CHANNEL_COUNT(4), .ADDRESS_BUS_WIDTH(13), .DATA_WIDTH(16)) busB();

   spi_word_router #(.CHANNEL_COUNT(4), .ADDRESS_BUS_WIDTH(13), .DATA_WIDTH(16)) dutA (
      .clk(clk), .rst_n(rst_n), .bus(busA)
   );
   spi_word_router #(.CHANNEL_COUNT(4), .ADDRESS_BUS_WIDTH(13), .DATA_WIDTH(16),
                     .CHANNEL_WORDS(WORDS_B)) dutB (
      .clk(clk), .rst_n(rst_n), .bus(busB)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Reference model: walk the regions in order, find the one holding the address.
   function automatic evT modelWrite(input int d, input int addr, input logic [15:0] data);
      evT e;
      int off;
      int hitCh;
      int localA;
      bit allDone;
      off = 0; hitCh = -1; localA = 0;
      e.cycle = 0; e.strobe = '0; e.last = '0; e.commit = 1'b0; e.oor = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (addr >= off && addr < off + words[d][i]) begin
            hitCh = i;
            localA = addr - off;
         end
         off += words[d][i];
      end
      if (hitCh < 0) begin
         e.oor = 1'b1;
         if (mDrops[d] < 65535) mDrops[d]++;
      end else begin
         e.strobe[hitCh] = 1'b1;
         mData[d] = data;
         mAddr[d][hitCh*AW +: AW] = 14'(localA);
         if (localA == words[d][hitCh] - 1) begin
            e.last[hitCh] = 1'b1;
            mSeen[d][hitCh] = 1'b1;
            allDone = 1'b1;
            for (int j = 0; j < 4; j++) if (words[d][j] > 0 && !mSeen[d][j]) allDone = 1'b0;
            if (allDone) begin
               e.commit = 1'b1;
               mSeen[d] = '0;
            end
         end
      end
      e.data = mData[d];
      e.addr = mAddr[d];
`ifdef SPI_WORD_ROUTER_STATS_EN
      e.drops = 16'(mDrops[d]);
`else
      e.drops = 16'd0;
`endif
      return e;
   endfunction

   task automatic applyStimulus(input int d, input int addr, input logic [15:0] data, input bit strobe);
      evT e;
      @(negedge clk);
      busA.spi_write_strobe = 1'b0;
      busB.spi_write_strobe = 1'b0;
      if (d == 0) begin
         busA.spi_word_address = 14'(addr);
         busA.spi_data         = data;
         busA.spi_write_strobe = strobe;
      end else begin
         busB.spi_word_address = 14'(addr);
         busB.spi_data         = data;
         busB.spi_write_strobe = strobe;
      end
      if (strobe) begin
         e = modelWrite(d, addr, data);
         e.cycle = cycle + 1;
         if (d == 0) expA.push_back(e);
         else        expB.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         busA.spi_write_strobe = 1'b0;
         busB.spi_write_strobe = 1'b0;
      end
   endtask

   task automatic compareEvent(input string tag, input evT e, input logic [3:0] strobe,
                               input logic [3:0] last, input logic commit, input logic oor,
                               input logic [15:0] data, input logic [55:0] addr, input logic [15:0] drops);
      checkOutput({tag, " cycle"}, 64'(cycle), 64'(e.cycle));
      checkOutput({tag, " ch_write_strobe"}, 64'(strobe), 64'(e.strobe));
      checkOutput({tag, " ch_last_word"}, 64'(last), 64'(e.last));
      checkOutput({tag, " frame_commit"}, 64'(commit), 64'(e.commit));
      checkOutput({tag, " out_of_range"}, 64'(oor), 64'(e.oor));
      checkOutput({tag, " ch_data"}, 64'(data), 64'(e.data));
      checkOutput({tag, " ch_address"}, 64'(addr), 64'(e.addr));
      checkOutput({tag, " drop_count"}, 64'(drops), 64'(e.drops));
   endtask

   task automatic checkResetState();
      checkOutput("rst A outputs", {busA.ch_data, busA.ch_write_strobe, busA.ch_last_word,
                  busA.frame_commit, busA.out_of_range, busA.drop_count}, 64'd0);
      checkOutput("rst A ch_address", 64'(busA.ch_address), 64'd0);
      checkOutput("rst B outputs", {busB.ch_data, busB.ch_write_strobe, busB.ch_last_word,
                  busB.frame_commit, busB.out_of_range, busB.drop_count}, 64'd0);
      checkOutput("rst B ch_address", 64'(busB.ch_address), 64'd0);
   endtask

   task automatic resetModel();
      for (int d = 0; d < 2; d++) begin
         mSeen[d] = '0; mData[d] = '0; mAddr[d] = '0; mDrops[d] = 0;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && (busA.ch_write_strobe != 0 || busA.ch_last_word != 0 || busA.frame_commit || busA.out_of_range)) begin
         if (expA.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL A unexpected output strobe=%b oor=%b required no output", busA.ch_write_strobe, busA.out_of_range);
         end else begin
            curA = expA.pop_front();
            compareEvent("A", curA, busA.ch_write_strobe, busA.ch_last_word, busA.frame_commit,
                         busA.out_of_range, busA.ch_data, busA.ch_address, busA.drop_count);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && (busB.ch_write_strobe != 0 || busB.ch_last_word != 0 || busB.frame_commit || busB.out_of_range)) begin
         if (expB.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL B unexpected output strobe=%b oor=%b required no output", busB.ch_write_strobe, busB.out_of_range);
         end else begin
            curB = expB.pop_front();
            compareEvent("B", curB, busB.ch_write_strobe, busB.ch_last_word, busB.frame_commit,
                         busB.out_of_range, busB.ch_data, busB.ch_address, busB.drop_count);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lastWords[4];
      int perm[4];
      int tmp;
      int j;
      int sel;
      int addr;
      words[0] = '{2688, 2688, 1344, 96};
      words[1] = '{0, 0, 0, 10};
      lastWords = '{2687, 5375, 6719, 6815};
      resetModel();
      busA.spi_data = '0; busA.spi_word_address = '0; busA.spi_write_strobe = 1'b0;
      busB.spi_data = '0; busB.spi_word_address = '0; busB.spi_write_strobe = 1'b0;
      repeat (3) @(negedge clk);
      checkResetState();
      rst_n = 1'b1;

      applyStimulus(0, 2688, 16'hBEEF, 1'b1);
      applyStimulus(0, 6815, 16'h1234, 1'b1);
      idle(2);
      for (int rep = 0; rep < 2; rep++) begin
         perm = lastWords;
         for (int i = 3; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
         end
         for (int i = 0; i < 4; i++) applyStimulus(0, perm[i], 16'($urandom), 1'b1);
      end
      applyStimulus(0, 6816, 16'hAAAA, 1'b1);
      applyStimulus(0, 16383, 16'h5555, 1'b1);
      idle(2);

      applyStimulus(1, 9, 16'h0909, 1'b1);
      applyStimulus(1, 10, 16'h1010, 1'b1);
      applyStimulus(1, 3, 16'h0303, 1'b1);
      applyStimulus(1, 9, 16'h9999, 1'b1);
      idle(3);

      applyStimulus(0, 2687, 16'h0001, 1'b1);
      applyStimulus(0, 5375, 16'h0002, 1'b1);
      idle(3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkResetState();
      resetModel();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 6719, 16'h0003, 1'b1);
      applyStimulus(0, 6815, 16'h0004, 1'b1);
      idle(2);

      for (int n = 0; n < 600; n++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0:       addr = lastWords[$urandom_range(0, 3)];
            1:       addr = $urandom_range(0, 6815);
            2:       addr = $urandom_range(0, 16383);
            default: addr = $urandom_range(6810, 6820);
         endcase
         applyStimulus(0, addr, 16'($urandom), $urandom_range(0, 3) != 0);
      end
      idle(2);
      for (int n = 0; n < 150; n++) begin
         applyStimulus(1, $urandom_range(0, 15), 16'($urandom), $urandom_range(0, 3) != 0);
      end
      idle(2);

`ifdef SPI_WORD_ROUTER_STATS_EN
      for (int n = 0; n < 65537; n++) applyStimulus(0, $urandom_range(6816, 16383), 16'($urandom), 1'b1);
      idle(2);
`endif

      for (int k = 0; k < 20 && (expA.size() != 0 || expB.size() != 0); k++) @(negedge clk);
      checkOutput("A pending", 64'(expA.size()), 64'd0);
      checkOutput("B pending", 64'(expB.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
